// File: rtl/radio_rx_pkg.sv
// Shared types and helpers for the multi-channel RC PWM receiver.
// Channel FSM encoding, default counter widths and index/saturation helpers.
package radio_rx_pkg;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_IDLE  = 2'd2
   } state_e;

   localparam int unsigned PW_W_DFLT = 12;
   localparam int unsigned TO_W_DFLT = 16;

   // All-ones value of a w-bit counter, i.e. the point where it saturates.
   function automatic longint unsigned sat_val(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/radio_rx_multi_if.sv
// Register-bank side bundle of the multi-channel receiver.
// The receiver core uses the slave modport; the pin/host side uses master.
interface radio_rx_multi_if #(
   parameter int CHANNELS = 4,
   parameter int PW_W     = 12
);
   logic [CHANNELS-1:0]      RADIO_IN;
   logic [CHANNELS-1:0]      CLR_ERR;
   logic [CHANNELS*PW_W-1:0] PULSE_WIDTH;
   logic [CHANNELS-1:0]      VALID_STB;
   logic [CHANNELS-1:0]      ONLINE;
   logic [CHANNELS-1:0]      ERR_FLAG;

   modport slave (
      input  RADIO_IN, CLR_ERR,
      output PULSE_WIDTH, VALID_STB, ONLINE, ERR_FLAG
   );

   modport master (
      output RADIO_IN, CLR_ERR,
      input  PULSE_WIDTH, VALID_STB, ONLINE, ERR_FLAG
   );
endinterface

// File: rtl/radio_rx_ch.sv
// One RC PWM channel: synchroniser, registered edge detect, WAIT/COUNT/IDLE
// FSM with loss-of-signal timer, validity window and failsafe output.
module radio_rx_ch
   import radio_rx_pkg::*;
#(
   parameter int PW_W        = PW_W_DFLT,
   parameter int TO_W        = TO_W_DFLT,
   parameter int TIMEOUT     = 32768,
   parameter int MIN_PW      = 800,
   parameter int MAX_PW      = 2200,
   parameter int FAILSAFE    = 1500,
   parameter int SYNC_STAGES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_radio,
   input  logic            i_clr_err,
   output logic [PW_W-1:0] o_pulse_width,
   output logic            o_valid_stb,
   output logic            o_online,
   output logic            o_err_flag
);

   localparam logic [PW_W-1:0] PCNT_SAT   = PW_W'(sat_val(PW_W));
   localparam logic [TO_W-1:0] WCNT_SAT   = TO_W'(sat_val(TO_W));
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [PW_W-1:0] FAILSAFE_W = PW_W'(FAILSAFE);
   localparam logic [PW_W:0]   MIN_W      = (PW_W+1)'(MIN_PW);
   localparam logic [PW_W:0]   MAX_W      = (PW_W+1)'(MAX_PW);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_edge_p;
   logic                   r_edge_n;
   state_e                 r_state;
   logic [PW_W-1:0]        r_pcnt;
   logic [TO_W-1:0]        r_wcnt;
   logic [PW_W-1:0]        r_pw;
   logic                   r_stb;
   logic                   r_online;
   logic                   r_err;

   logic                   w_synced;
   logic [PW_W:0]          w_width;
   logic                   w_accept;
   logic [TO_W-1:0]        w_wcnt_inc;
   logic                   w_set_err;

   assign w_synced   = r_sync[SYNC_STAGES-1];
   // Extra bit so a width of 2**PW_W never wraps into the accept window.
   assign w_width    = {1'b0, r_pcnt} + (PW_W+1)'(1);
   assign w_accept   = (w_width >= MIN_W) && (w_width <= MAX_W);
   assign w_wcnt_inc = (r_wcnt == WCNT_SAT) ? r_wcnt : r_wcnt + TO_W'(1);
   assign w_set_err  = (r_state == ST_COUNT) &&
                       ((r_pcnt == PCNT_SAT) || (r_edge_n && !w_accept));

   // Edges are registered so the FSM sees one clean single-cycle pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync   <= '0;
         r_prev   <= 1'b0;
         r_edge_p <= 1'b0;
         r_edge_n <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value, so the shift chain really is a chain.
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_radio};
         r_prev   <= w_synced;
         r_edge_p <= w_synced & ~r_prev;
         r_edge_n <= ~w_synced & r_prev;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_WAIT;
         r_pcnt   <= '0;
         r_wcnt   <= '0;
         r_pw     <= FAILSAFE_W;
         r_stb    <= 1'b0;
         r_online <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_stb <= 1'b0;

         // Set has priority over a coincident clear.
         if (w_set_err)      r_err <= 1'b1;
         else if (i_clr_err) r_err <= 1'b0;

         case (r_state)
            ST_WAIT: begin
               r_pcnt   <= '0;
               r_wcnt   <= '0;
               r_online <= 1'b0;
               r_pw     <= FAILSAFE_W;
               if (r_edge_p) r_state <= ST_COUNT;
            end
            ST_COUNT: begin
               r_wcnt <= w_wcnt_inc;
               if (r_pcnt == PCNT_SAT) begin
                  r_state  <= ST_WAIT;
                  r_pcnt   <= '0;
                  r_wcnt   <= '0;
                  r_online <= 1'b0;
                  r_pw     <= FAILSAFE_W;
               end else if (r_edge_n) begin
                  r_state <= ST_IDLE;
                  if (w_accept) begin
                     r_pw     <= w_width[PW_W-1:0];
                     r_stb    <= 1'b1;
                     r_online <= 1'b1;
                  end
               end else begin
                  r_pcnt <= r_pcnt + PW_W'(1);
               end
            end
            ST_IDLE: begin
               if (r_edge_p) begin
                  r_state <= ST_COUNT;
                  r_pcnt  <= '0;
                  r_wcnt  <= '0;
               end else if (r_wcnt == TO_LAST) begin
                  r_state  <= ST_WAIT;
                  r_wcnt   <= '0;
                  r_online <= 1'b0;
                  r_pw     <= FAILSAFE_W;
               end else begin
                  r_wcnt <= w_wcnt_inc;
               end
            end
            default: r_state <= ST_WAIT;
         endcase
      end
   end

   assign o_pulse_width = r_pw;
   assign o_valid_stb   = r_stb;
   assign o_online      = r_online;
   assign o_err_flag    = r_err;

endmodule

// File: rtl/radio_rx_multi.sv
// Multi-channel RC PWM receiver: CHANNELS independent radio_rx_ch instances
// whose outputs are packed onto the register-bank interface.
module radio_rx_multi
   import radio_rx_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int PW_W        = PW_W_DFLT,
   parameter int TO_W        = TO_W_DFLT,
   parameter int TIMEOUT     = 32768,
   parameter int MIN_PW      = 800,
   parameter int MAX_PW      = 2200,
   parameter int FAILSAFE    = 1500,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET_N,
   radio_rx_multi_if.slave  bus
);

   logic [PW_W-1:0] w_pw  [CHANNELS];
   logic            w_stb [CHANNELS];
   logic            w_onl [CHANNELS];
   logic            w_err [CHANNELS];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      radio_rx_ch #(
         .PW_W        (PW_W),
         .TO_W        (TO_W),
         .TIMEOUT     (TIMEOUT),
         .MIN_PW      (MIN_PW),
         .MAX_PW      (MAX_PW),
         .FAILSAFE    (FAILSAFE),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .i_clk         (CLK),
         .i_rst_n       (RESET_N),
         .i_radio       (bus.RADIO_IN[g]),
         .i_clr_err     (bus.CLR_ERR[g]),
         .o_pulse_width (w_pw[g]),
         .o_valid_stb   (w_stb[g]),
         .o_online      (w_onl[g]),
         .o_err_flag    (w_err[g])
      );
   end

   // NOTE: every output bit is assigned on every pass, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         bus.PULSE_WIDTH[ch_lsb(i, PW_W) +: PW_W] = w_pw[i];
         bus.VALID_STB[i] = w_stb[i];
         bus.ONLINE[i]    = w_onl[i];
         bus.ERR_FLAG[i]  = w_err[i];
      end
   end

endmodule
